sd_data_serial_card: RTL and testbench

- Card-side (device-end) 4-bit SD DAT line engine, the counterpart of the host data serializer.
- Receives host write blocks: start bit, data, per-line CRC16, end bit. Returns the CRC status token and holds busy on DAT0.
- Transmits read blocks: start bit, data, CRC16, end bit.
- Used as a synthesizable card model for controller bring-up and as the data path of an SD target core. Word side connects to FIFOs in the same clock domain.

---
 rtl/sd_data_serial_card.sv | 236 +++++++++++++++++++++++
 tb/tb_sd_data_serial_card.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_data_serial_card.sv
// Card-side 4-bit SD DAT engine: receives write blocks (CRC token + busy)
// and transmits read blocks, with four CRC16 lanes.
module sd_data_serial_card #(
  parameter int BLOCK_WORDS = 128
) (
  input  logic        sd_clk,
  input  logic        rst,
  input  logic [3:0]  DAT_dat_i,
  output logic [3:0]  DAT_dat_o,
  output logic        DAT_oe_o,
  input  logic        start_rx,
  input  logic        start_tx,
  input  logic        abort,
  input  logic        busy_hold,
  output logic [31:0] data_out,
  output logic        we,
  input  logic [31:0] data_in,
  output logic        rd,
  output logic        crc_ok,
  output logic        rx_done,
  output logic        tx_done,
  output logic        card_busy
);

  localparam int NIBS = 8 * BLOCK_WORDS;
  localparam int NW   = $clog2(NIBS) + 1;
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBS - 1);
  localparam logic [NW-1:0] LAST_RD  = NW'(NIBS - 8);

  typedef enum logic [3:0] {
    IDLE, RX_WAIT, RX_DATA, RX_CRC, RX_END, RX_TOKEN,
    RX_BUSY, TX_LOAD, TX_DATA, TX_CRC, TX_END
  } state_e;

  function automatic logic [15:0] crc_step(
    input logic [15:0] c,
    input logic        b
  );
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  state_e            state_q, state_d;
  logic [NW-1:0]     cnt_q, cnt_d;
  logic [31:0]       sh_q, sh_d;
  logic [31:0]       pf_q, pf_d;
  logic [3:0][15:0]  crc_q, crc_d;
  logic [3:0][15:0]  rcrc_q, rcrc_d;
  logic [3:0]        dat_q, dat_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [31:0]       dout_q, dout_d;
  logic              ok_q, ok_d;
  logic              rxd_q, rxd_d;
  logic              txd_q, txd_d;
  logic [31:0]       word_c;

  // Registered DAT outputs: each state computes what the wire shows next.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    pf_d    = pf_q;
    crc_d   = crc_q;
    rcrc_d  = rcrc_q;
    dat_d   = 4'hF;
    oe_d    = 1'b0;
    we_d    = 1'b0;
    dout_d  = dout_q;
    ok_d    = ok_q;
    rxd_d   = 1'b0;
    txd_d   = 1'b0;
    rd      = 1'b0;
    word_c  = sh_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_rx)      state_d = RX_WAIT;
        else if (start_tx) state_d = TX_LOAD;
      end
      RX_WAIT: begin
        if (DAT_dat_i == 4'h0) begin
          state_d = RX_DATA;
          cnt_d   = '0;
          crc_d   = '0;
        end
      end
      RX_DATA: begin
        sh_d = {sh_q[27:0], DAT_dat_i};
        for (int i = 0; i < 4; i++)
          crc_d[i] = crc_step(crc_q[i], DAT_dat_i[i]);
        if (cnt_q[2:0] == 3'd7) begin
          dout_d = {sh_q[27:0], DAT_dat_i};
          we_d   = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          state_d = RX_CRC;
          cnt_d   = '0;
        end
      end
      RX_CRC: begin
        for (int i = 0; i < 4; i++)
          rcrc_d[i] = {rcrc_q[i][14:0], DAT_dat_i[i]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[3:0] == 4'd15) begin
          state_d = RX_END;
          cnt_d   = '0;
        end
      end
      RX_END: begin
        ok_d    = (rcrc_q == crc_q) && (DAT_dat_i == 4'hF);
        oe_d    = 1'b1;
        state_d = RX_TOKEN;
        cnt_d   = '0;
      end
      RX_TOKEN: begin
        oe_d  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        case (cnt_q[2:0])
          3'd0: dat_d = 4'hE;
          3'd1: dat_d = {3'b111, ~ok_q};
          3'd2: dat_d = {3'b111, ok_q};
          3'd3: dat_d = {3'b111, ~ok_q};
          3'd4: dat_d = 4'hF;
          default: begin
            dat_d   = 4'hE;
            state_d = RX_BUSY;
            cnt_d   = '0;
          end
        endcase
      end
      RX_BUSY: begin
        oe_d = 1'b1;
        if (busy_hold) begin
          dat_d = 4'hE;
        end else begin
          rxd_d   = 1'b1;
          state_d = IDLE;
        end
      end
      TX_LOAD: begin
        rd      = 1'b1;
        oe_d    = 1'b1;
        dat_d   = 4'h0;
        crc_d   = '0;
        cnt_d   = '0;
        state_d = TX_DATA;
      end
      TX_DATA: begin
        oe_d = 1'b1;
        if (cnt_q == '0)             word_c = data_in;
        else if (cnt_q[2:0] == 3'd0) word_c = pf_q;
        sh_d  = {word_c[27:0], 4'h0};
        dat_d = word_c[31:28];
        for (int i = 0; i < 4; i++)
          crc_d[i] = crc_step(crc_q[i], word_c[28+i]);
        if (cnt_q[2:0] == 3'd7) pf_d = data_in;
        if (cnt_q[2:0] == 3'd6 && cnt_q < LAST_RD) rd = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          state_d = TX_CRC;
          cnt_d   = '0;
        end
      end
      TX_CRC: begin
        oe_d = 1'b1;
        for (int i = 0; i < 4; i++)
          dat_d[i] = crc_q[i][4'd15 - cnt_q[3:0]];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[3:0] == 4'd15) begin
          state_d = TX_END;
          cnt_d   = '0;
        end
      end
      TX_END: begin
        oe_d    = 1'b1;
        txd_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
      dat_d   = 4'hF;
      we_d    = 1'b0;
      dout_d  = dout_q;
      rxd_d   = 1'b0;
      txd_d   = 1'b0;
      rd      = 1'b0;
    end
  end

  always_ff @(posedge sd_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      pf_q    <= '0;
      crc_q   <= '0;
      rcrc_q  <= '0;
      dat_q   <= 4'hF;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      dout_q  <= '0;
      ok_q    <= 1'b0;
      rxd_q   <= 1'b0;
      txd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      pf_q    <= pf_d;
      crc_q   <= crc_d;
      rcrc_q  <= rcrc_d;
      dat_q   <= dat_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      dout_q  <= dout_d;
      ok_q    <= ok_d;
      rxd_q   <= rxd_d;
      txd_q   <= txd_d;
    end
  end

  assign DAT_dat_o = dat_q;
  assign DAT_oe_o  = oe_q;
  assign data_out  = dout_q;
  assign we        = we_q;
  assign crc_ok    = ok_q;
  assign rx_done   = rxd_q;
  assign tx_done   = txd_q;
  assign card_busy = (state_q != IDLE);

endmodule

// File: tb/tb_sd_data_serial_card.sv
// Bench for sd_data_serial_card: host-side block driver, FIFO model and
// polynomial-division CRC reference.
module tb_sd_data_serial_card;

  localparam int BW   = 128;
  localparam int NIBS = 8 * BW;

  logic        sd_clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  DAT_dat_i = 4'hF;
  logic [3:0]  DAT_dat_o;
  logic        DAT_oe_o;
  logic        start_rx = 1'b0;
  logic        start_tx = 1'b0;
  logic        abort = 1'b0;
  logic        busy_hold = 1'b0;
  logic [31:0] data_out;
  logic        we;
  logic [31:0] data_in = '0;
  logic        rd;
  logic        crc_ok;
  logic        rx_done;
  logic        tx_done;
  logic        card_busy;

  sd_data_serial_card #(.BLOCK_WORDS(BW)) dut (
    .sd_clk(sd_clk), .rst(rst),
    .DAT_dat_i(DAT_dat_i), .DAT_dat_o(DAT_dat_o), .DAT_oe_o(DAT_oe_o),
    .start_rx(start_rx), .start_tx(start_tx), .abort(abort),
    .busy_hold(busy_hold), .data_out(data_out), .we(we),
    .data_in(data_in), .rd(rd), .crc_ok(crc_ok),
    .rx_done(rx_done), .tx_done(tx_done), .card_busy(card_busy)
  );

  always #5 sd_clk = ~sd_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_rd = 0;
  int n_rxd = 0;
  int n_txd = 0;
  logic [31:0] rxq[$];
  logic [31:0] fifo[$];
  logic [31:0] blk[BW];
  logic pop_pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge sd_clk) begin
    pop_pend = rd;
    if (rd) n_rd++;
    if (we) rxq.push_back(data_out);
    if (rx_done) n_rxd++;
    if (tx_done) n_txd++;
  end

  // FIFO with registered output: word appears the cycle after rd
  always @(posedge sd_clk) begin
    if (pop_pend) begin
      #1;
      data_in = (fifo.size() > 0) ? fifo.pop_front() : 32'hDEAD_BEEF;
    end
  end

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int j);
    return 4'(w >> (28 - 4 * j));
  endfunction

  // CRC = remainder of (message * x^16) / (x^16+x^12+x^5+1)
  function automatic logic [15:0] lane_crc(input int l);
    logic [16:0] r;
    logic [3:0]  nb;
    logic        b;
    r = '0;
    for (int n = 0; n < NIBS + 16; n++) begin
      if (n < NIBS) begin
        nb = nib_of(blk[n / 8], n % 8);
        b  = nb[l];
      end else begin
        b = 1'b0;
      end
      r = {r[15:0], b};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  task automatic rx_block(input bit do_start, input int flip_n,
                          input logic [3:0] endn, input int hold,
                          input bit exp_ok);
    logic [31:0] sent[BW];
    logic [15:0] c[4];
    logic [3:0]  tok[8];
    int          base;
    for (int l = 0; l < 4; l++) c[l] = lane_crc(l);
    sent = blk;
    if (flip_n >= 0)
      sent[flip_n / 8] ^= (32'h4 << (28 - 4 * (flip_n % 8)));
    rxq.delete();
    base = n_rxd;
    busy_hold = (hold > 0);
    if (do_start) begin
      start_rx = 1'b1;
      @(negedge sd_clk);
      start_rx = 1'b0;
    end
    repeat ($urandom_range(1, 4)) begin
      DAT_dat_i = 4'($urandom_range(1, 15));
      @(negedge sd_clk);
    end
    DAT_dat_i = 4'h0;
    @(negedge sd_clk);
    for (int n = 0; n < NIBS; n++) begin
      DAT_dat_i = nib_of(sent[n / 8], n % 8);
      @(negedge sd_clk);
    end
    for (int b = 0; b < 16; b++) begin
      DAT_dat_i = {c[3][15-b], c[2][15-b], c[1][15-b], c[0][15-b]};
      @(negedge sd_clk);
    end
    DAT_dat_i = endn;
    @(negedge sd_clk);
    DAT_dat_i = 4'hF;
    tok[1] = 4'hF;
    tok[2] = 4'hE;
    tok[3] = {3'b111, ~exp_ok};
    tok[4] = {3'b111, exp_ok};
    tok[5] = {3'b111, ~exp_ok};
    tok[6] = 4'hF;
    tok[7] = 4'hE;
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge sd_clk);
      check($sformatf("token E+%0d", k), {DAT_oe_o, DAT_dat_o},
            {1'b1, tok[k]});
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge sd_clk);
      check("busy", {DAT_oe_o, DAT_dat_o}, {1'b1, 4'hE});
    end
    busy_hold = 1'b0;
    @(negedge sd_clk);
    check("busy_end", {DAT_oe_o, DAT_dat_o, rx_done}, {1'b1, 4'hF, 1'b1});
    @(negedge sd_clk);
    check("rx_idle", {DAT_oe_o, card_busy}, 2'b00);
    check("crc_ok", crc_ok, exp_ok);
    check("rx_done_cnt", n_rxd - base, 1);
    check("we_cnt", rxq.size(), BW);
    for (int k = 0; k < BW && k < rxq.size(); k++)
      check($sformatf("rx_word%0d", k), rxq[k], sent[k]);
  endtask

  task automatic wait_oe();
    for (int t = 0; t < 8 && !DAT_oe_o; t++) @(negedge sd_clk);
  endtask

  task automatic tx_block();
    logic [31:0] w;
    logic [15:0] c[4];
    int          base_rd;
    int          base_td;
    fifo.delete();
    for (int k = 0; k < BW; k++) fifo.push_back(blk[k]);
    base_rd = n_rd;
    base_td = n_txd;
    start_tx = 1'b1;
    @(negedge sd_clk);
    start_tx = 1'b0;
    wait_oe();
    check("tx_start", {DAT_oe_o, DAT_dat_o}, {1'b1, 4'h0});
    for (int k = 0; k < BW; k++) begin
      w = '0;
      for (int j = 0; j < 8; j++) begin
        @(negedge sd_clk);
        w = {w[27:0], DAT_dat_o};
      end
      check($sformatf("tx_word%0d", k), w, blk[k]);
    end
    for (int l = 0; l < 4; l++) c[l] = '0;
    for (int b = 0; b < 16; b++) begin
      @(negedge sd_clk);
      for (int l = 0; l < 4; l++) c[l] = {c[l][14:0], DAT_dat_o[l]};
    end
    for (int l = 0; l < 4; l++)
      check($sformatf("tx_crc%0d", l), c[l], lane_crc(l));
    @(negedge sd_clk);
    check("tx_end", {DAT_oe_o, DAT_dat_o, tx_done}, {1'b1, 4'hF, 1'b1});
    @(negedge sd_clk);
    check("tx_idle", {DAT_oe_o, card_busy}, 2'b00);
    check("rd_cnt", n_rd - base_rd, BW);
    check("tx_done_cnt", n_txd - base_td, 1);
  endtask

  task automatic fill_random();
    for (int k = 0; k < BW; k++) blk[k] = $urandom;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(negedge sd_clk);
    check("reset_vals",
          {DAT_oe_o, DAT_dat_o, we, rd, crc_ok, rx_done, tx_done,
           card_busy, data_out},
          {1'b0, 4'hF, 6'b0, 32'h0});
    rst = 1'b1;
    @(negedge sd_clk);

    start_rx = 1'b1;
    start_tx = 1'b1;
    @(negedge sd_clk);
    start_rx = 1'b0;
    start_tx = 1'b0;
    check("both_start", {card_busy, rd, DAT_oe_o}, 3'b100);
    start_tx = 1'b1;
    @(negedge sd_clk);
    start_tx = 1'b0;
    check("tx_ignored", {card_busy, rd, DAT_oe_o}, 3'b100);
    @(negedge sd_clk);
    check("tx_ignored2", {card_busy, rd, DAT_oe_o}, 3'b100);

    for (int k = 0; k < BW; k++) blk[k] = 32'(k);
    rx_block(1'b0, -1, 4'hF, 3, 1'b1);
    rx_block(1'b1, 1, 4'hF, 0, 1'b0);
    rx_block(1'b1, -1, 4'hE, 2, 1'b0);
    fill_random();
    rx_block(1'b1, -1, 4'hF, $urandom_range(0, 5), 1'b1);

    for (int k = 0; k < BW; k++) begin
      blk[k] = '0;
      for (int j = 0; j < 8; j++)
        blk[k] = {blk[k][27:0], 4'((8 * k + j) & 15)};
    end
    tx_block();
    fill_random();
    tx_block();
    check("ok_after_tx", crc_ok, 1'b1);

    base = n_rxd;
    start_rx = 1'b1;
    @(negedge sd_clk);
    start_rx = 1'b0;
    DAT_dat_i = 4'h0;
    @(negedge sd_clk);
    for (int n = 0; n < 300; n++) begin
      DAT_dat_i = 4'($urandom);
      @(negedge sd_clk);
    end
    abort = 1'b1;
    @(negedge sd_clk);
    abort = 1'b0;
    DAT_dat_i = 4'hF;
    check("abort_rx", {DAT_oe_o, DAT_dat_o, card_busy}, {1'b0, 4'hF, 1'b0});
    repeat (3) @(negedge sd_clk);
    check("abort_rx_done", n_rxd - base, 0);
    check("ok_after_abort", crc_ok, 1'b1);
    fill_random();
    rx_block(1'b1, -1, 4'hF, $urandom_range(1, 4), 1'b1);

    base = n_txd;
    fifo.delete();
    for (int k = 0; k < BW; k++) fifo.push_back(blk[k]);
    start_tx = 1'b1;
    @(negedge sd_clk);
    start_tx = 1'b0;
    wait_oe();
    repeat (NIBS + 5) @(negedge sd_clk);
    abort = 1'b1;
    @(negedge sd_clk);
    abort = 1'b0;
    check("abort_tx", {DAT_oe_o, DAT_dat_o, card_busy}, {1'b0, 4'hF, 1'b0});
    repeat (3) @(negedge sd_clk);
    check("abort_tx_done", n_txd - base, 0);

    fifo.delete();
    for (int k = 0; k < BW; k++) fifo.push_back(blk[k]);
    start_tx = 1'b1;
    @(negedge sd_clk);
    start_tx = 1'b0;
    wait_oe();
    repeat (50) @(negedge sd_clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset",
          {DAT_oe_o, DAT_dat_o, we, rd, crc_ok, rx_done, tx_done,
           card_busy, data_out},
          {1'b0, 4'hF, 6'b0, 32'h0});
    @(negedge sd_clk);
    rst = 1'b1;
    @(negedge sd_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
